mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the memory data width.
REQ-003 The block SHALL have parameter TMO, default 15, giving the maximum cycles to wait for MEM_READY (range 1..15).
REQ-004 The block SHALL have the following ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- CPU_REQ  in  1  CPU control-unit access request; held high until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ is high.
- CPU_ADDR  in  ADDR_W  CPU address; stable while CPU_REQ is high.
- CPU_WDATA  in  DATA_W  CPU write data.
- CPU_ACK  out  1  one-cycle completion pulse to the CPU.
- DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_ACK  same as the CPU set, for the DMA/IO requester.
- RDATA  out  DATA_W  captured read data; valid in the ACK cycle.
- BUS_ERR  out  1  asserted with ACK when the access timed out.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RDATA  in  DATA_W  memory read data; valid when MEM_READY=1.
- MEM_READY  in  1  memory completion for the current access.
- OWNER  out  2  00 = none, 01 = CPU, 10 = DMA.

Function
REQ-005 State machine SHALL have states IDLE, CPU_BUSY, DMA_BUSY, DONE; there SHALL be no other reachable state.
REQ-006 IDLE SHALL behave as follows:
- Only CPU_REQ=1: go to CPU_BUSY.
- Only DMA_REQ=1: go to DMA_BUSY.
- Neither: stay in IDLE.
REQ-007 When both requests are high in IDLE, the grant SHALL go to the requester not recorded in the LAST register; LAST SHALL update to the granted requester on every grant.
REQ-008 On a grant, the block SHALL register the winner's WE, ADDR and WDATA into MEM_WE, MEM_ADDR and MEM_WDATA; these SHALL be stable for the whole BUSY period.
REQ-009 MEM_EN SHALL be 1 exactly while the state is CPU_BUSY or DMA_BUSY; OWNER SHALL reflect the BUSY owner and be 00 otherwise.
REQ-010 In BUSY, MEM_READY=1 SHALL cause a transition to DONE; for reads, MEM_RDATA SHALL be captured into RDATA at that edge.
REQ-011 A 4-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle in which MEM_READY=0.
REQ-012 When the wait counter reaches TMO with MEM_READY=0, the block SHALL go to DONE with BUS_ERR=1 and RDATA unchanged.
REQ-013 MEM_READY arriving in the same cycle the counter reaches TMO SHALL count as success, with BUS_ERR=0.
REQ-014 DONE SHALL last exactly one cycle.
REQ-015 In DONE, the owner's ACK SHALL be 1 and the other ACK SHALL be 0.
REQ-016 DONE SHALL always go to IDLE, and no arbitration SHALL occur in DONE.
REQ-017 A requester SHALL deassert its REQ in the cycle after its ACK; REQ high in IDLE is treated as a new request.
REQ-018 Latency: REQ sampled high in IDLE at edge N puts MEM_EN=1 in cycle N+1; MEM_READY at edge M gives ACK in cycle M+1; the minimum REQ-to-ACK is 2 cycles.
REQ-019 A request that arrives while the other requester owns the memory SHALL wait with no loss and be granted in the next IDLE.
REQ-020 RDATA SHALL hold its value on writes and between accesses.
REQ-021 BUS_ERR SHALL be 0 outside DONE.

Reset
REQ-022 RESET_N=0 SHALL immediately, without waiting for a clock edge, set the following:
- state = IDLE.
- LAST = DMA, so the CPU wins the first tie.
- Wait counter = 0.
- All outputs (CPU_ACK, DMA_ACK, BUS_ERR, MEM_EN, MEM_WE, OWNER) = 0.
- MEM_ADDR, MEM_WDATA, RDATA = 0.
REQ-023 A reset during BUSY or DONE SHALL abandon the access with no ACK issued.
REQ-024 Operation SHALL resume from IDLE on the first rising edge after RESET_N deasserts.

Verification
REQ-025 The bench SHALL cover each of the following directed scenarios:
- CPU read: CPU_REQ=1, ADDR=0x10, MEM_READY in the first BUSY cycle with MEM_RDATA=0x5A -> MEM_EN for 1 cycle, CPU_ACK=1 and RDATA=0x5A two cycles after the request.
- Tie: CPU_REQ and DMA_REQ rise together straight after reset -> CPU granted first, DMA granted next, OWNER sequence 01,00,00,10.
- Back-to-back ties: both requesters repeatedly re-request for 4 rounds -> grants strictly alternate CPU, DMA, CPU, DMA.
- Timeout: DMA write with MEM_READY held 0 -> MEM_EN high for exactly 15 cycles, then DMA_ACK=1 and BUS_ERR=1, RDATA unchanged.
- Timeout edge: MEM_READY=1 in the 15th wait cycle -> ACK with BUS_ERR=0.
- Reset mid-access: RESET_N pulsed low during CPU_BUSY -> MEM_EN=0 at once, no CPU_ACK, then a fresh grant after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a CPU control unit and a DMA/IO engine share
// one memory port. Ties in IDLE go to whichever requester did not win last,
// each access is bounded by a wait timeout, and completion is a one-cycle ACK.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int TMO    = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic [ADDR_W-1:0] DMA_ADDR,
    input  logic [DATA_W-1:0] DMA_WDATA,
    output logic              DMA_ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUS_ERR,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY,
    output logic [1:0]        OWNER
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    // The wait counter value at the start of the final permitted BUSY cycle;
    // one more cycle without MEM_READY makes it reach TMO and ends the access.
    localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_cpu;

    // Arbitration: a lone requester wins; on a tie the one that did not win last.
    always_comb begin
        grant_cpu = CPU_REQ && (!DMA_REQ || last_q);
    end

    // Next-state logic: grant in IDLE, wait for MEM_READY or timeout in BUSY,
    // single-cycle DONE that always returns to IDLE without arbitrating.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    state_d     = CPU_BUSY;
                    last_d      = 1'b0;
                    wait_cnt_d  = 4'd0;
                    mem_we_d    = CPU_WE;
                    mem_addr_d  = CPU_ADDR;
                    mem_wdata_d = CPU_WDATA;
                end else if (DMA_REQ) begin
                    state_d     = DMA_BUSY;
                    last_d      = 1'b1;
                    wait_cnt_d  = 4'd0;
                    mem_we_d    = DMA_WE;
                    mem_addr_d  = DMA_ADDR;
                    mem_wdata_d = DMA_WDATA;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                if (MEM_READY) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = MEM_RDATA;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_q == TMO_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight and favours the CPU.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            wait_cnt_q  <= 4'd0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Outputs decode straight from registered state, so they clear with reset.
    always_comb begin
        MEM_EN    = (state_q == CPU_BUSY) || (state_q == DMA_BUSY);
        OWNER     = (state_q == CPU_BUSY) ? 2'b01 :
                    (state_q == DMA_BUSY) ? 2'b10 : 2'b00;
        CPU_ACK   = (state_q == DONE) && !last_q;
        DMA_ACK   = (state_q == DONE) && last_q;
        BUS_ERR   = (state_q == DONE) && err_q;
        MEM_WE    = mem_we_q;
        MEM_ADDR  = mem_addr_q;
        MEM_WDATA = mem_wdata_q;
        RDATA     = rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays both requesters and the memory,
// tracks pending requests, the last winner and the expected read data at
// transaction level, and checks the arbiter cycle by cycle.
module tb_mem_arbiter;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_ack, dma_ack, bus_err, mem_en, mem_we, mem_ready;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] owner;

    int   checks = 0;
    int   errors = 0;
    bit   last_dma;
    bit   cpu_pend, dma_pend;
    logic [7:0] exp_rdata;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TMO(TMO)) dut (
        .CLK(clk), .RESET_N(reset_n),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr),
        .CPU_WDATA(cpu_wdata), .CPU_ACK(cpu_ack),
        .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr),
        .DMA_WDATA(dma_wdata), .DMA_ACK(dma_ack),
        .RDATA(rdata), .BUS_ERR(bus_err),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_READY(mem_ready),
        .OWNER(owner)
    );

    always #5 clk = ~clk;

    // Arbitration rule: lone requester wins, a tie goes to the non-last winner.
    function automatic bit pick_cpu();
        if (cpu_pend && dma_pend) return last_dma;
        return cpu_pend;
    endfunction

    task automatic raise_cpu(input bit we, input logic [7:0] addr, input logic [7:0] wd);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; cpu_pend = 1'b1;
    endtask

    task automatic raise_dma(input bit we, input logic [7:0] addr, input logic [7:0] wd);
        dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1; dma_pend = 1'b1;
    endtask

    // One access, entered at the falling edge of an IDLE cycle with requests
    // already driven. Memory answers in BUSY cycle lat+1 unless that exceeds TMO.
    task automatic run_access(input bit is_cpu, input int lat, input logic [7:0] rd,
                              input bit late_join, output int busy_len);
        logic       e_we;
        logic [7:0] e_addr, e_wd;
        bit         done, timed_out;
        e_we   = is_cpu ? cpu_we : dma_we;
        e_addr = is_cpu ? cpu_addr : dma_addr;
        e_wd   = is_cpu ? cpu_wdata : dma_wdata;
        last_dma = !is_cpu;
        busy_len = 0; done = 0; timed_out = 0;
        while (!done) begin
            @(negedge clk);
            busy_len++;
            checks++;
            if ({mem_en, owner, cpu_ack, dma_ack, bus_err} !==
                {1'b1, (is_cpu ? 2'b01 : 2'b10), 3'b000}) begin
                errors++;
                $display("[TB] FAIL busy_ctrl cycle %0d: got en/own/acks/err=%b expected %b", busy_len,
                         {mem_en, owner, cpu_ack, dma_ack, bus_err}, {1'b1, (is_cpu ? 2'b01 : 2'b10), 3'b000});
            end
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wd}) begin
                errors++;
                $display("[TB] FAIL busy_bus cycle %0d: got we/addr/wd=%b/%h/%h expected %b/%h/%h",
                         busy_len, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
            end
            if (late_join && busy_len == 1) begin
                if (is_cpu && !dma_pend) raise_dma(1'($urandom), 8'($urandom), 8'($urandom));
                if (!is_cpu && !cpu_pend) raise_cpu(1'($urandom), 8'($urandom), 8'($urandom));
            end
            if (busy_len == lat + 1) begin
                mem_ready = 1'b1; mem_rdata = rd; done = 1;
            end else begin
                mem_ready = 1'b0; mem_rdata = 8'($urandom);
                if (busy_len == TMO) begin
                    done = 1; timed_out = 1;
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        if (!timed_out && !e_we) exp_rdata = rd;
        checks++;
        if ({mem_en, owner, cpu_ack, dma_ack, bus_err} !==
            {1'b0, 2'b00, is_cpu, !is_cpu, timed_out}) begin
            errors++;
            $display("[TB] FAIL done_ctrl: got en/own/cack/dack/err=%b expected %b",
                     {mem_en, owner, cpu_ack, dma_ack, bus_err}, {1'b0, 2'b00, is_cpu, !is_cpu, timed_out});
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("[TB] FAIL done_rdata: got %h expected %h", rdata, exp_rdata);
        end
        if (is_cpu) begin cpu_req = 1'b0; cpu_pend = 1'b0; end
        else begin dma_req = 1'b0; dma_pend = 1'b0; end
    endtask

    // Step into the IDLE cycle after DONE and confirm everything is quiet.
    task automatic idle_step(input string tag);
        @(negedge clk);
        checks++;
        if ({mem_en, owner, cpu_ack, dma_ack, bus_err} !== 5'b0 || rdata !== exp_rdata) begin
            errors++;
            $display("[TB] FAIL %s_idle: got en/own/acks/err=%b rdata=%h expected 00000 rdata=%h",
                     tag, {mem_en, owner, cpu_ack, dma_ack, bus_err}, rdata, exp_rdata);
        end
    endtask

    // Serve every pending request in arbitration order.
    task automatic serve_pending(input bit random_lat, input bit allow_join);
        int blen;
        int guard = 0;
        while ((cpu_pend || dma_pend) && guard < 10) begin
            run_access(pick_cpu(), random_lat ? int'($urandom_range(0, 17)) : 0, 8'($urandom),
                       allow_join && guard < 4 && $urandom_range(0, 2) == 0, blen);
            idle_step("serve");
            guard++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_dma = 1'b1; exp_rdata = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, dma_ack, bus_err, mem_en, mem_we, owner} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {cpu_ack, dma_ack, bus_err, mem_en, mem_we, owner});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr/wd/rd=%h/%h/%h expected 00/00/00", mem_addr, mem_wdata, rdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        last_dma = 1'b1; exp_rdata = 8'h00;
        idle_step("reset");
    endtask

    task automatic test_cpu_read();
        int blen;
        raise_cpu(1'b0, 8'h10, 8'hEE);
        run_access(1'b1, 0, 8'h5A, 1'b0, blen);
        checks++;
        if (blen != 1 || rdata !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL cpu_read: got busy=%0d rdata=%h expected busy=1 rdata=5a", blen, rdata);
        end
        idle_step("cpu_read");
    endtask

    task automatic test_tie();
        int blen;
        pulse_reset();
        raise_cpu(1'b1, 8'h21, 8'h33);
        raise_dma(1'b0, 8'h42, 8'h00);
        run_access(1'b1, 1, 8'h00, 1'b0, blen);
        idle_step("tie");
        run_access(1'b0, 0, 8'h77, 1'b0, blen);
        idle_step("tie2");
    endtask

    task automatic test_back_to_back();
        int blen;
        for (int r = 0; r < 4; r++) begin
            if (!cpu_pend) raise_cpu(1'($urandom), 8'($urandom), 8'($urandom));
            if (!dma_pend) raise_dma(1'($urandom), 8'($urandom), 8'($urandom));
            run_access(r % 2 == 0, int'($urandom_range(0, 3)), 8'($urandom), 1'b0, blen);
            idle_step("b2b");
        end
        serve_pending(1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int blen;
        raise_dma(1'b1, 8'h80, 8'hA5);
        run_access(1'b0, 99, 8'h11, 1'b0, blen);
        checks++;
        if (blen != TMO) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d expected %0d", blen, TMO);
        end
        idle_step("timeout");
        raise_cpu(1'b0, 8'h81, 8'h00);
        run_access(1'b1, 40, 8'h99, 1'b0, blen);
        idle_step("timeout_rd");
    endtask

    task automatic test_timeout_edge();
        int blen;
        raise_cpu(1'b0, 8'h90, 8'h00);
        run_access(1'b1, TMO - 1, 8'hC3, 1'b0, blen);
        checks++;
        if (blen != TMO || rdata !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL timeout_edge: got busy=%0d rdata=%h expected busy=%0d rdata=c3", blen, rdata, TMO);
        end
        idle_step("timeout_edge");
    endtask

    task automatic test_reset_mid();
        int blen;
        raise_cpu(1'b0, 8'h55, 8'h00);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_busy: got mem_en=%b expected 1", mem_en);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, owner} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_mid_async: got en/own=%b expected 000", {mem_en, owner});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_ack, dma_ack, rdata, mem_addr} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_hold: got cack/dack/rdata/addr=%b/%b/%h/%h expected 0/0/00/00",
                     cpu_ack, dma_ack, rdata, mem_addr);
        end
        reset_n = 1'b1;
        last_dma = 1'b1; exp_rdata = 8'h00;
        run_access(1'b1, 2, 8'h3C, 1'b0, blen);
        idle_step("rst_mid");
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(1, 3));
            if (sel[0]) raise_cpu(1'($urandom), 8'($urandom), 8'($urandom));
            if (sel[1]) raise_dma(1'($urandom), 8'($urandom), 8'($urandom));
            serve_pending(1'b1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
